// File: rtl/mips_pkg.sv
// mips_pkg: shared opcode constants and opcode width for the 16-bit MIPS core
package mips_pkg;
  localparam int OP_W = 6;
  localparam logic [OP_W-1:0] OP_LD  = 6'b010100;
  localparam logic [OP_W-1:0] OP_JMP = 6'b011110;
  localparam logic [OP_W-1:0] OP_HLT = 6'b010001;
endpackage

// File: rtl/stall_control_block_if.sv
// stall_control_block_if: decode-opcode in, stall requests out
interface stall_control_block_if;
  import mips_pkg::*;
  logic [0:OP_W-1] op;
  logic            stall;
  logic            stall_pm;
  modport master (output op, input stall, stall_pm);
  modport slave  (input op, output stall, stall_pm);
endinterface

// File: rtl/stall_control_block.sv
// stall_control_block: load/jump/halt stall generator; STALL_CTRL_HALT_LATCH_EN makes halt sticky until reset
module stall_control_block
  import mips_pkg::*;
#(
  parameter logic [0:OP_W-1] LD_OP  = OP_LD,
  parameter logic [0:OP_W-1] JMP_OP = OP_JMP,
  parameter logic [0:OP_W-1] HLT_OP = OP_HLT
) (
  input logic clk,
  input logic reset,
  stall_control_block_if.slave bus
);
  logic ld_q, jmp_q, halt_q, pm_q;
  logic ld_hit, jmp_hit, hlt_hit;
  // opcode decode; a load or jump already in flight masks its own re-trigger for one cycle
  always_comb begin
    ld_hit    = (bus.op == LD_OP) & ~ld_q;
    jmp_hit   = (bus.op == JMP_OP) & ~jmp_q;
    hlt_hit   = bus.op == HLT_OP;
    bus.stall = reset & (ld_hit | jmp_hit | jmp_q | hlt_hit | halt_q);
  end
  assign bus.stall_pm = pm_q;
  // bubble tracking and the one-cycle delayed copy for program memory
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ld_q  <= 1'b0;
      jmp_q <= 1'b0;
      pm_q  <= 1'b0;
    end else begin
      ld_q  <= ld_hit;
      jmp_q <= jmp_hit;
      pm_q  <= bus.stall;
    end
  end
`ifdef STALL_CTRL_HALT_LATCH_EN
  // halt stays latched until reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) halt_q <= 1'b0;
    else        halt_q <= halt_q | hlt_hit;
  end
`else
  assign halt_q = 1'b0;
`endif
endmodule

// File: tb/tb_stall_control_block.sv
// tb_stall_control_block: scoreboard bench for stall_control_block
module tb_stall_control_block;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int errors = 0;
  int checks = 0;
  logic [1:0] sb[$];
  localparam logic [5:0] NOP = 6'b000000;
  localparam logic [5:0] LD  = 6'b010100;
  localparam logic [5:0] JMP = 6'b011110;
  localparam logic [5:0] HLT = 6'b010001;
  localparam logic [5:0] BAD = 6'b111111;
`ifdef STALL_CTRL_HALT_LATCH_EN
  localparam bit LATCH = 1'b1;
`else
  localparam bit LATCH = 1'b0;
`endif

  stall_control_block_if bus ();
  stall_control_block dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input logic [5:0] v, input logic s, input logic p);
    @(posedge clk);
    #1;
    bus.op = v;
    sb.push_back({s, p});
  endtask

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      logic [1:0] e;
      e = sb.pop_front();
      check("stall", bus.stall, e[1]);
      check("stall_pm", bus.stall_pm, e[0]);
    end
  end

  initial begin
    bus.op = NOP;
    #2;
    check("rst_stall", bus.stall, 1'b0);
    check("rst_pm", bus.stall_pm, 1'b0);
    reset = 1'b1;
    #1;
    check("rel_stall", bus.stall, 1'b0);
    check("rel_pm", bus.stall_pm, 1'b0);
    drive(NOP, 0, 0);
    drive(LD, 1, 0);
    drive(LD, 0, 1);
    drive(NOP, 0, 0);
    drive(JMP, 1, 0);
    drive(NOP, 1, 1);
    drive(NOP, 0, 1);
    drive(NOP, 0, 0);
    drive(JMP, 1, 0);
    drive(JMP, 1, 1);
    drive(JMP, 1, 1);
    drive(NOP, 1, 1);
    drive(NOP, 0, 1);
    drive(NOP, 0, 0);
    drive(LD, 1, 0);
    drive(LD, 0, 1);
    drive(LD, 1, 0);
    drive(NOP, 0, 1);
    drive(BAD, 0, 0);
    drive(HLT, 1, 0);
    drive(NOP, LATCH, 1);
    for (int i = 0; i < 4; i++) drive(NOP, LATCH, LATCH);
    @(negedge clk);
    #2;
    bus.op = HLT;
    reset = 1'b0;
    #1;
    check("mid_rst_stall", bus.stall, 1'b0);
    check("mid_rst_pm", bus.stall_pm, 1'b0);
    bus.op = NOP;
    reset = 1'b1;
    drive(NOP, 0, 0);
    drive(HLT, 1, 0);
    drive(NOP, LATCH, 1);
    drive(NOP, LATCH, LATCH);
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
    @(posedge clk);
    if (sb.size() != 0) check("drain", 1'b1, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/stall_control_block.md
Name: stall_control_block

Overview:
- Pipeline hazard/stall generator for the 16-bit MIPS core; sits beside the fetch/decode stages.
- Decodes the 6-bit opcode currently in decode and asserts `stall`, which freezes the PC and the IF/ID register.
  - Load: 1-cycle bubble.
  - Jump: 2-cycle bubble.
  - Halt: stall until reset.
- `stall_pm` is a one-cycle-delayed copy of `stall`, used to gate the program-memory read/enable.

Parameters:
- LD_OP, 6'b010100, load opcode; costs 1 stall cycle.
- JMP_OP, 6'b011110, jump opcode; costs 2 stall cycles.
- HLT_OP, 6'b010001, halt opcode; stalls indefinitely.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- op  in  6  opcode field of the instruction in decode; declared op[0:5], op[0] is the MSB.
- stall  out  1  combinational stall request to PC / IF-ID.
- stall_pm  out  1  registered stall for program memory; equals `stall` delayed by one clk.

Behaviour:
- State flops:
  - ld_q (load stall issued last cycle)
  - jmp_q (first jump stall cycle issued last cycle)
  - halt_q (halt latched)
  - pm_q (drives stall_pm)
- Reset (reset==0, asynchronous):
  - All flops clear to 0.
  - stall forced 0 and stall_pm = 0 for as long as reset is low, regardless of op.
  - Reset mid-stall aborts the stall immediately.
- Decode terms (reset high):
  - ld_hit = (op==LD_OP) & ~ld_q
  - jmp_hit = (op==JMP_OP) & ~jmp_q
  - hlt_hit = (op==HLT_OP)
- Stall equation: stall = ld_hit | jmp_hit | jmp_q | hlt_hit | halt_q.
- Next state on each rising clk:
  - ld_q <= ld_hit
  - jmp_q <= jmp_hit
  - halt_q <= halt_q | hlt_hit
  - pm_q <= stall
- Load timing:
  - stall is high in the first cycle op==LD_OP.
  - stall is low in the following cycle even if op is still LD_OP.
  - If op is still LD_OP in the third consecutive cycle, this is a new load and stall is high again (1-high / 1-low pattern).
- Jump timing:
  - stall is high in the cycle op==JMP_OP is first seen.
  - stall stays high the next cycle via jmp_q, whatever op is then.
  - If op is still JMP_OP in the third cycle, jmp_hit fires again (new jump).
- Halt:
  - stall rises combinationally when op==HLT_OP.
  - From the next edge, halt_q keeps stall high permanently until reset goes low.
- Simultaneous terms: OR-combined; no priority needed. halt_q dominates all others.
- stall_pm reflects the stall value sampled at the previous rising edge; no other latency in the block.
- No X propagation: an op that matches no opcode gives stall=0 unless a pending jmp_q or halt_q is set.

Optional Feature:
- Macro: STALL_CTRL_HALT_LATCH_EN.
- Defined: halt_q is implemented; HLT is sticky until reset, as described above.
- Undefined:
  - halt_q is removed (tie to 0).
  - stall is high only in cycles where op==HLT_OP.
  - stall_pm follows stall with one cycle delay as usual.

Decomposition:
- Shared package mips_pkg holds the opcode constants OP_LD, OP_JMP and OP_HLT (6-bit) and the opcode width (6). The parameter defaults take their values from this package.
- Single module, no sub-modules. The 1-bit delay flop for stall_pm is inline, not a separate instance.

Test Plan:
- Reset pulse: reset=0 for 2 ns with op=000000 -> stall=0 and stall_pm=0 immediately.
- Reset released with op=000000 -> stall=0, and stall_pm=0 on the next edge.
- Load: op=010100 held 2 clocks (10 ns period) -> stall=1 in clock 1, 0 in clock 2. stall_pm=1 in clock 2, 0 in clock 3.
- Jump: op=011110 for 1 clock, then 000000 -> stall=1 for exactly 2 clocks. stall_pm=1 for the 2 clocks delayed by one.
- Jump held 3 clocks: op=011110 -> stall pattern 1,1,1 (re-trigger in clock 3), then 1 more cycle from jmp_q.
- Halt: op=010001 for 1 clock, then op=000000 for 5 clocks.
  - With STALL_CTRL_HALT_LATCH_EN: stall stays 1 for all 5 clocks.
  - Without the macro: stall returns to 0 after 1 clock.
  - In both cases, async reset=0 drops stall and stall_pm at once.
